fir_coef_loader: RTL

- Writer side of the FIR coefficient bus: accepts coefficients one at a time over a valid/ready stream and assembles them in a shadow bank.
- Drives the packed coefs bus that the FIR tap chain reads.
- Commits the shadow bank to the active bus atomically, so the filter never sees a half-loaded set; pulses coef_upd on each commit.
- Sits between the control/host stream and the FIR datapath, all in the same clock domain.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_coef_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient bus: slot width, loader states,
// and the tap-to-slot mapping used by both the loader and the tap chain.
package fir_pkg;

   localparam int SLOT = 32;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMMIT
   } state_t;

   // Tap 0 lives in the most significant slot of the packed bus.
   function automatic int slot_lsb(input int tap, input int taps);
      return (taps - 1 - tap) * SLOT;
   endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Assembles a full coefficient set from a valid/ready stream into a shadow
// bank, then commits it to the packed coefs bus in a single edge.
module fir_coef_loader
   import fir_pkg::*;
#(
   parameter int CWIDTH = 16,
   parameter int TAPS   = 2
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [CWIDTH-1:0]    s_data,
   input  logic                 s_last,
   input  logic                 abort,
   output logic [TAPS*SLOT-1:0] coefs,
   output logic                 coef_upd,
   output logic                 busy,
   output logic                 err,
   input  logic                 err_clr
);

   localparam int CW = $clog2(TAPS);
   localparam logic [CW-1:0] LAST_IDX = CW'(TAPS - 1);

   state_t          state_reg, state_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [SLOT-1:0] shadow_reg [TAPS];
   logic [SLOT-1:0] shadow_next [TAPS];
   logic [SLOT-1:0] active_reg [TAPS];
   logic [SLOT-1:0] active_next [TAPS];
   logic            upd_reg, upd_next;
   logic            err_reg, err_next;
   logic            ready_en_reg;
   logic [SLOT-1:0] ext_data;
   logic            accept;
   logic            frame_err;

   assign ext_data = SLOT'($signed(s_data));
   // s_ready stays low until the first edge after reset release.
   assign s_ready  = ready_en_reg && (state_reg != COMMIT);
   assign accept   = s_valid && s_ready;
   assign busy     = (state_reg != IDLE);
   assign coef_upd = upd_reg;
   assign err      = err_reg;

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      shadow_next = shadow_reg;
      active_next = active_reg;
      upd_next    = 1'b0;
      frame_err   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (abort) begin
               count_next = '0;
            end else if (accept) begin
               if (s_last) begin
                  frame_err = 1'b1;
               end else begin
                  shadow_next[0] = ext_data;
                  count_next     = CW'(1);
                  state_next     = LOAD;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               count_next = '0;
               state_next = IDLE;
            end else if (accept) begin
               shadow_next[count_reg] = ext_data;
               if (count_reg == LAST_IDX) begin
                  if (s_last) state_next = COMMIT;
                  else        frame_err  = 1'b1;
               end else begin
                  if (s_last) frame_err  = 1'b1;
                  else        count_next = count_reg + CW'(1);
               end
            end
         end
         COMMIT: begin
            active_next = shadow_reg;
            upd_next    = 1'b1;
            count_next  = '0;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // A framing error throws away whatever was gathered so far.
      if (frame_err) begin
         for (int i = 0; i < TAPS; i++) shadow_next[i] = '0;
         count_next = '0;
         state_next = IDLE;
      end

      err_next = (err_reg && !err_clr) || frame_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         upd_reg      <= 1'b0;
         err_reg      <= 1'b0;
         ready_en_reg <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            shadow_reg[i] <= '0;
            active_reg[i] <= '0;
         end
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         upd_reg      <= upd_next;
         err_reg      <= err_next;
         ready_en_reg <= 1'b1;
         shadow_reg   <= shadow_next;
         active_reg   <= active_next;
      end
   end

   for (genvar gi = 0; gi < TAPS; gi++) begin : g_pack
      assign coefs[slot_lsb(gi, TAPS) +: SLOT] = active_reg[gi];
   end

endmodule
